// File: rtl/store_rmw_unit.sv
// Sequential store unit: word-aligns sub-word stores and merges them into memory via read-modify-write.
// Optional STORE_BYTE_EN_EN: drive byte enables instead and skip the read phase entirely.
module store_rmw_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_data,
  input  logic [1:0]          req_size,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd_en,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_rvalid,
  output logic                mem_wr_en,
  output logic [XLEN-1:0]     mem_wdata,
`ifdef STORE_BYTE_EN_EN
  output logic [XLEN/8-1:0]   mem_be,
`endif
  output logic                resp_valid,
  output logic                resp_err
);

  localparam int unsigned NBYTES  = XLEN / 8;
  localparam int unsigned OFF_W   = $clog2(NBYTES);
  localparam logic [1:0]  FULL_SZ = 2'(OFF_W);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [NBYTES-1:0]   be_q, be_d;
  logic                err_q, err_d;
  logic                legal;

  function automatic logic is_legal(input logic [2:0] lo, input logic [1:0] sz);
    case (sz)
      2'd0:    is_legal = 1'b1;
      2'd1:    is_legal = (lo[0] == 1'b0);
      2'd2:    is_legal = (lo[1:0] == 2'b00);
      default: is_legal = (XLEN == 64) && (lo == 3'b000);
    endcase
  endfunction

  // Aligned stores land in lanes whose index shares the offset's upper bits.
  function automatic logic [NBYTES-1:0] lane_mask(input logic [OFF_W-1:0] off, input logic [1:0] sz);
    lane_mask = '0;
    for (int unsigned i = 0; i < NBYTES; i++)
      lane_mask[i] = ((i >> sz) == (32'(off) >> sz));
  endfunction

  // Low size-bytes of d repeated across the word, so every aligned lane group sees the store data.
  function automatic logic [XLEN-1:0] replicate(input logic [XLEN-1:0] d, input logic [1:0] sz);
    replicate = '0;
    for (int unsigned i = 0; i < NBYTES; i++)
      replicate[8*i +: 8] = d[8*(i & ((32'd1 << sz) - 32'd1)) +: 8];
  endfunction

  assign legal = is_legal(req_addr[2:0], req_size);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          wdata_d = replicate(req_data, req_size);
          be_d    = lane_mask(req_addr[OFF_W-1:0], req_size);
          err_d   = !legal;
          if (!legal)
            state_d = RESP;
          else if (req_size == FULL_SZ)
            state_d = WR;
          else
`ifdef STORE_BYTE_EN_EN
            state_d = WR;
`else
            state_d = RD;
`endif
        end
      end
      RD: begin
        mem_rd_en = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          for (int unsigned i = 0; i < NBYTES; i++)
            wdata_d[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_rdata[8*i +: 8];
          state_d = WR;
        end
      end
      WR: begin
        mem_wr_en = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign resp_err  = resp_valid & err_q;
`ifdef STORE_BYTE_EN_EN
  assign mem_be    = be_q;
`endif

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed bench for store_rmw_unit (XLEN=32): RMW merge, full-width, illegal and reset-abort scenarios.
module tb_store_rmw_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
`ifdef STORE_BYTE_EN_EN
  logic [3:0]  mem_be;
  logic [3:0]  wr_be;
`endif
  logic        resp_valid;
  logic        resp_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int rd_cnt = 0, wr_cnt = 0, resp_cnt = 0;
  int rd_cyc = 0, wr_cyc = 0, resp_cyc = 0;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic resp_err_s, resp_ready_s;

  int base_rd, base_wr, base_resp, viol;

  store_rmw_unit #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
`ifdef STORE_BYTE_EN_EN
    .mem_be(mem_be),
`endif
    .resp_valid(resp_valid), .resp_err(resp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_rd_en) begin
      rd_cnt  = rd_cnt + 1;
      rd_cyc  = cyc;
      rd_addr = mem_addr;
    end
    if (mem_wr_en) begin
      wr_cnt  = wr_cnt + 1;
      wr_cyc  = cyc;
      wr_addr = mem_addr;
      wr_data = mem_wdata;
`ifdef STORE_BYTE_EN_EN
      wr_be   = mem_be;
`endif
    end
    if (resp_valid) begin
      resp_cnt     = resp_cnt + 1;
      resp_cyc     = cyc;
      resp_err_s   = resp_err;
      resp_ready_s = req_ready;
    end
  end

  // Issue one request, answer its read after `delay` WAIT cycles, and return until the response.
  task automatic run_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                           input logic [31:0] rdata, input int delay, output int t);
    bit rd_seen = 0, given = 0, done = 0;
    int w = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_data = data; req_size = size;
    t = cyc;
    base_rd = rd_cnt; base_wr = wr_cnt; base_resp = resp_cnt; viol = 0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_data = 32'hFFFF_FFFF; req_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk); #1;
      if (rd_cnt > base_rd && !rd_seen) rd_seen = 1;
      else if (rd_seen && !given) begin
        if (w == delay) begin
          mem_rdata = rdata; mem_rvalid = 1'b1; given = 1;
        end else w++;
      end else if (given) mem_rvalid = 1'b0;
      if (rd_seen && resp_cnt == base_resp && req_ready) viol++;
      if (resp_cnt > base_resp) done = 1;
    end
    mem_rvalid = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL timeout addr=%h: no resp_valid within 40 cycles", addr);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    tests++; if (mem_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd got %b exp 0", mem_rd_en); end
    tests++; if (mem_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr got %b exp 0", mem_wr_en); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp got %b exp 0", resp_valid); end
    tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
    tests++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata got %h exp 0", mem_wdata); end
  endtask

  task automatic test_sb();
    int t;
    run_store(32'h1002, 32'h0000_00AB, 2'd0, 32'h1122_3344, 0, t);
    tests++; if (rd_cnt - base_rd != 1) begin fails++; $display("FAIL sb_rd_count got %0d exp 1", rd_cnt - base_rd); end
    tests++; if (rd_addr !== 32'h1000) begin fails++; $display("FAIL sb_rd_addr got %h exp 00001000", rd_addr); end
    tests++; if (wr_cnt - base_wr != 1) begin fails++; $display("FAIL sb_wr_count got %0d exp 1", wr_cnt - base_wr); end
    tests++; if (wr_addr !== 32'h1000) begin fails++; $display("FAIL sb_wr_addr got %h exp 00001000", wr_addr); end
    tests++; if (wr_data !== 32'h11AB_3344) begin fails++; $display("FAIL sb_wdata got %h exp 11ab3344", wr_data); end
    tests++; if (resp_err_s !== 1'b0) begin fails++; $display("FAIL sb_err got %b exp 0", resp_err_s); end
    tests++; if (resp_cyc != t + 4) begin fails++; $display("FAIL sb_latency got %0d exp 4", resp_cyc - t); end
  endtask

  task automatic test_sh_delayed();
    int t;
    run_store(32'h2002, 32'h0000_BEEF, 2'd1, 32'hCAFE_D00D, 5, t);
    tests++; if (viol != 0) begin fails++; $display("FAIL sh_ready_busy got %0d cycles exp 0", viol); end
    tests++; if (wr_data !== 32'hBEEF_D00D) begin fails++; $display("FAIL sh_wdata got %h exp beefd00d", wr_data); end
    tests++; if (wr_cnt - base_wr != 1) begin fails++; $display("FAIL sh_wr_count got %0d exp 1", wr_cnt - base_wr); end
    tests++; if (resp_cyc != t + 9) begin fails++; $display("FAIL sh_latency got %0d exp 9", resp_cyc - t); end
  endtask

  task automatic test_sw();
    int t;
    run_store(32'h3000, 32'hDEAD_BEEF, 2'd2, 32'h0, 0, t);
    tests++; if (rd_cnt != base_rd) begin fails++; $display("FAIL sw_no_read got %0d reads exp 0", rd_cnt - base_rd); end
    tests++; if (wr_cyc != t + 1) begin fails++; $display("FAIL sw_wr_cycle got %0d exp 1", wr_cyc - t); end
    tests++; if (wr_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL sw_wdata got %h exp deadbeef", wr_data); end
    tests++; if (resp_cyc != t + 2) begin fails++; $display("FAIL sw_latency got %0d exp 2", resp_cyc - t); end
    tests++; if (resp_ready_s !== 1'b0) begin fails++; $display("FAIL sw_ready_in_resp got %b exp 0", resp_ready_s); end
    @(negedge clk); #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL sw_ready_after got %b exp 1", req_ready); end
  endtask

  task automatic test_illegal();
    logic [31:0] addrs [2] = '{32'h3001, 32'h3003};
    logic [1:0]  sizes [2] = '{2'd2, 2'd1};
    int t;
    for (int k = 0; k < 2; k++) begin
      run_store(addrs[k], 32'h1234_5678, sizes[k], 32'h0, 0, t);
      tests++; if (rd_cnt != base_rd || wr_cnt != base_wr) begin
        fails++; $display("FAIL illegal%0d_strobes got rd=%0d wr=%0d exp 0 0", k, rd_cnt - base_rd, wr_cnt - base_wr); end
      tests++; if (resp_cyc != t + 1) begin fails++; $display("FAIL illegal%0d_latency got %0d exp 1", k, resp_cyc - t); end
      tests++; if (resp_err_s !== 1'b1) begin fails++; $display("FAIL illegal%0d_err got %b exp 1", k, resp_err_s); end
    end
  endtask

  task automatic test_reset_abort();
    int t, w0, r0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h40; req_data = 32'h77; req_size = 2'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    w0 = wr_cnt; r0 = resp_cnt;
    reset_n = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    tests++; if (wr_cnt != w0) begin fails++; $display("FAIL abort_no_write got %0d writes exp 0", wr_cnt - w0); end
    tests++; if (resp_cnt != r0) begin fails++; $display("FAIL abort_no_resp got %0d resps exp 0", resp_cnt - r0); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL abort_ready got %b exp 1", req_ready); end
    run_store(32'h0, 32'h0000_005A, 2'd0, 32'h0, 0, t);
    tests++; if (wr_cnt - base_wr != 1) begin fails++; $display("FAIL abort_next_wr_count got %0d exp 1", wr_cnt - base_wr); end
    tests++; if (wr_data !== 32'h0000_005A) begin fails++; $display("FAIL abort_next_wdata got %h exp 0000005a", wr_data); end
  endtask

`ifdef STORE_BYTE_EN_EN
  task automatic test_byte_en();
    int t;
    run_store(32'h0000_0002, 32'h0000_1234, 2'd1, 32'h0, 0, t);
    tests++; if (rd_cnt != base_rd) begin fails++; $display("FAIL be_no_read got %0d reads exp 0", rd_cnt - base_rd); end
    tests++; if (wr_be !== 4'b1100) begin fails++; $display("FAIL be_mask got %b exp 1100", wr_be); end
    tests++; if (wr_data[31:16] !== 16'h1234) begin fails++; $display("FAIL be_wdata got %h exp 1234", wr_data[31:16]); end
    tests++; if (resp_cyc != t + 2) begin fails++; $display("FAIL be_latency got %0d exp 2", resp_cyc - t); end
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk); reset_n = 1'b1;
`ifdef STORE_BYTE_EN_EN
    test_byte_en();
`else
    test_sb();
    test_sh_delayed();
    test_reset_abort();
`endif
    test_sw();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
